// File: rtl/stack_ctrl.sv
// stack_ctrl: keeps top-of-stack in a register and sequences the RAM stack below it.
// Define STACK_CTRL_GUARD_EN to drop overflowing/underflowing commands and raise sticky error flags.
module stack_ctrl #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16,
  parameter int DW    = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             err_clr,
  output logic             stk_we,
  output logic [1:0]       stk_delta,
  output logic [WIDTH-1:0] stk_wd,
  input  logic [WIDTH-1:0] stk_rd
);
`ifdef STACK_CTRL_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif
  localparam logic [DW-1:0] FULL_D = DW'(DEPTH + 1);
  typedef enum logic {IDLE, SETTLE} state_t;
  typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_SWAP = 2'b10, OP_REPL = 2'b11} op_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_tos, w_tos;
  logic [DW-1:0]    r_depth, w_depth;
  logic             r_ovf, r_unf, w_set_ovf, w_set_unf, w_acc, w_ge2;
  assign cmd_ready = (r_state == IDLE);
  assign w_acc     = cmd_valid & cmd_ready;
  assign empty     = (r_depth == '0);
  assign full      = (r_depth == FULL_D);
  assign w_ge2     = (r_depth >= DW'(2));
  assign tos       = r_tos;
  assign nos       = stk_rd;
  assign depth     = r_depth;
  assign stk_wd    = r_tos;
  assign err_ovf   = GUARD & r_ovf;
  assign err_unf   = GUARD & r_unf;
  // T and depth move on the accepting edge; RAM ops then wait one cycle for the registered read
  always_comb begin
    w_next    = IDLE;
    w_tos     = r_tos;
    w_depth   = r_depth;
    stk_we    = 1'b0;
    stk_delta = 2'b00;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (w_acc) begin
      case (cmd_op)
        OP_PUSH:
          if (empty) begin
            w_tos   = cmd_data;
            w_depth = DW'(1);
          end else if (GUARD && full) begin
            w_set_ovf = 1'b1;
          end else begin
            stk_we    = 1'b1;
            stk_delta = 2'b01;
            w_tos     = cmd_data;
            w_depth   = r_depth + DW'(1);
            w_next    = SETTLE;
          end
        OP_POP:
          if (r_depth == DW'(1)) begin
            w_depth = '0;
          end else if (GUARD && empty) begin
            w_set_unf = 1'b1;
          end else begin
            stk_delta = 2'b11;
            w_tos     = stk_rd;
            w_depth   = r_depth - DW'(1);
            w_next    = SETTLE;
          end
        OP_SWAP:
          if (GUARD && !w_ge2) begin
            w_set_unf = 1'b1;
          end else begin
            stk_we = 1'b1;
            w_tos  = stk_rd;
            w_next = SETTLE;
          end
        default: begin
          w_tos   = cmd_data;
          w_depth = empty ? DW'(1) : r_depth;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tos   <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tos   <= w_tos;
      r_depth <= w_depth;
      r_ovf   <= w_set_ovf | (r_ovf & ~err_clr);
      r_unf   <= w_set_unf | (r_unf & ~err_clr);
    end
  end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed scoreboard bench for stack_ctrl with a registered-read RAM stack model.
module tb_stack_ctrl;
  localparam int DEPTH = 6;
  localparam int WIDTH = 16;
  localparam int DW    = $clog2(DEPTH + 2);
`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, err_clr;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data, tos, nos, stk_wd, stk_rd;
  logic [DW-1:0]    depth;
  logic             empty, full, err_ovf, err_unf, stk_we;
  logic [1:0]       stk_delta;
  stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .tos(tos), .nos(nos), .depth(depth),
    .empty(empty), .full(full), .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr),
    .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd)
  );
  always #5 clk = ~clk;
  logic [WIDTH-1:0] mem [0:7];
  logic [2:0]       sp;
  always @(posedge clk) begin
    if (stk_delta == 2'b01) mem[sp + 3'd1] <= stk_wd;
    else if (stk_delta == 2'b00 && stk_we) mem[sp] <= stk_wd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp     <= '0;
      stk_rd <= '0;
    end else begin
      if (stk_delta == 2'b01) sp <= sp + 3'd1;
      else if (stk_delta == 2'b11) sp <= sp - 3'd1;
      stk_rd <= mem[sp];
    end
  end
  typedef struct {
    logic [WIDTH-1:0] tos;
    int               depth;
    logic             ovf;
    logic             unf;
    logic             acc;
  } exp_t;
  exp_t             sb[$];
  int               tests = 0, fails = 0;
  int               m_depth = 0;
  logic [WIDTH-1:0] m_tos = '0;
  logic [WIDTH-1:0] m_stk[$];
  logic             m_ovf = 1'b0, m_unf = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_tos"}, 32'(tos), 32'd0);
    chk({tag, "_depth"}, 32'(depth), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ovf"}, 32'(err_ovf), 32'd0);
    chk({tag, "_unf"}, 32'(err_unf), 32'd0);
    chk({tag, "_we"}, 32'(stk_we), 32'd0);
    chk({tag, "_delta"}, 32'(stk_delta), 32'd0);
  endtask
  task automatic cmd(input logic [1:0] op, input logic [WIDTH-1:0] d, input logic clr);
    int               n;
    logic             ewe, so, su, acc;
    logic [1:0]       edl;
    logic [WIDTH-1:0] ewd, tmp;
    exp_t             e;
    n = 0;
    while (!cmd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ready_bound", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; err_clr = clr;
    ewe = 1'b0; edl = 2'b00; ewd = m_tos; so = 1'b0; su = 1'b0; acc = 1'b0;
    case (op)
      2'd0:
        if (m_depth == 0) begin
          m_tos = d; m_depth = 1;
        end else if (GUARD && m_depth == DEPTH + 1) so = 1'b1;
        else begin
          ewe = 1'b1; edl = 2'b01; acc = 1'b1;
          m_stk.push_back(m_tos); m_tos = d; m_depth = (m_depth + 1) % (1 << DW);
        end
      2'd1:
        if (m_depth == 1) m_depth = 0;
        else if (m_depth >= 2) begin
          edl = 2'b11; acc = 1'b1;
          m_tos = m_stk.pop_back(); m_depth--;
        end else su = 1'b1;
      2'd2:
        if (m_depth >= 2) begin
          ewe = 1'b1; acc = 1'b1;
          tmp = m_stk[m_stk.size() - 1];
          m_stk[m_stk.size() - 1] = m_tos;
          m_tos = tmp;
        end else su = 1'b1;
      default: begin
        if (m_depth == 0) m_depth = 1;
        m_tos = d;
      end
    endcase
    m_ovf = GUARD & (so | (m_ovf & !clr));
    m_unf = GUARD & (su | (m_unf & !clr));
    #1;
    chk("stk_we", 32'(stk_we), 32'(ewe));
    chk("stk_delta", 32'(stk_delta), 32'(edl));
    if (ewe) chk("stk_wd", 32'(stk_wd), 32'(ewd));
    e = '{tos: m_tos, depth: m_depth, ovf: m_ovf, unf: m_unf, acc: acc};
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; err_clr = 1'b0;
    e = sb.pop_front();
    chk("tos", 32'(tos), 32'(e.tos));
    chk("depth", 32'(depth), 32'(e.depth));
    chk("empty", 32'(empty), 32'(e.depth == 0));
    chk("full", 32'(full), 32'(e.depth == DEPTH + 1));
    chk("err_ovf", 32'(err_ovf), 32'(e.ovf));
    chk("err_unf", 32'(err_unf), 32'(e.unf));
    chk("ready_after", 32'(cmd_ready), 32'(!e.acc));
    if (e.acc) begin
      @(posedge clk);
      #1;
      chk("ready_settled", 32'(cmd_ready), 32'd1);
    end
    if (m_depth >= 2) chk("nos", 32'(nos), 32'(m_stk[m_stk.size() - 1]));
    @(negedge clk);
  endtask
  task automatic clr_only();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
    chk("clr_ovf", 32'(err_ovf), 32'd0);
    chk("clr_unf", 32'(err_unf), 32'd0);
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_rst("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cmd(2'd0, 16'h1111, 1'b0);
    chk("tp1_tos", 32'(tos), 32'h1111);
    cmd(2'd0, 16'h2222, 1'b0);
    cmd(2'd0, 16'h3333, 1'b0);
    chk("tp2_depth", 32'(depth), 32'd3);
    cmd(2'd2, 16'h0000, 1'b0);
    chk("tp3_swap_nos", 32'(nos), 32'h3333);
    cmd(2'd1, 16'h0000, 1'b0);
    chk("tp3_pop1", 32'(tos), 32'h3333);
    cmd(2'd1, 16'h0000, 1'b0);
    chk("tp3_pop2", 32'(tos), 32'h1111);
    cmd(2'd3, 16'hBEEF, 1'b0);
    chk("tp4_repl", 32'(tos), 32'hBEEF);
    for (int i = 0; i < 3; i++) cmd(2'd0, 16'($urandom), 1'b0);
    cmd(2'd2, 16'h0000, 1'b0);
    cmd(2'd3, 16'h7777, 1'b0);
    for (int i = 0; i < 3; i++) cmd(2'd1, 16'h0000, 1'b0);
    while (m_depth < DEPTH + 1) cmd(2'd0, 16'($urandom), 1'b0);
    chk("full_flag", 32'(full), 32'd1);
`ifdef STACK_CTRL_GUARD_EN
    cmd(2'd0, 16'hDEAD, 1'b1);
    chk("ovf_set_wins", 32'(err_ovf), 32'd1);
    chk("ovf_depth_held", 32'(depth), 32'(DEPTH + 1));
    while (m_depth > 0) cmd(2'd1, 16'h0000, 1'b0);
    cmd(2'd1, 16'h0000, 1'b0);
    chk("unf_pop_empty", 32'(err_unf), 32'd1);
    cmd(2'd2, 16'h0000, 1'b0);
    cmd(2'd0, 16'h4444, 1'b0);
    cmd(2'd2, 16'h0000, 1'b0);
    chk("unf_swap_tos_held", 32'(tos), 32'h4444);
`else
    cmd(2'd0, 16'hDEAD, 1'b0);
    chk("wrap_depth", 32'(depth), 32'd0);
`endif
    clr_only();
    cmd(2'd0, 16'h0A0A, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'h9999;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("settle_seen", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_rst("rst_settle");
    @(negedge clk);
    rst_n = 1'b1;
    m_depth = 0; m_tos = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    cmd(2'd0, 16'h5555, 1'b0);
    chk("post_rst_depth", 32'(depth), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
